// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem request, 2-entry in-order decode FIFO with PC/fault tags.
// Accept-to-inst_valid is 3 cycles with zero-wait memory; pc_ready drops while busy, full or flushing.
module fetch_unit #(
  parameter int                MXLEN    = 32,
  parameter logic [MXLEN-1:0]  NOP_INST = 'h13
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [MXLEN-1:0] pc_val,
  input  logic             pc_valid,
  output logic             pc_ready,
  input  logic             flush,
  output logic             imem_req,
  output logic [MXLEN-1:0] imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [MXLEN-1:0] imem_rdata,
  input  logic             imem_err,
  output logic             inst_valid,
  output logic [MXLEN-1:0] inst_data,
  output logic [MXLEN-1:0] inst_pc,
  output logic [1:0]       inst_fault,
  input  logic             inst_ready
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN_REQ, DRAIN} state_t;

  typedef struct packed {
    logic [MXLEN-1:0] dat;
    logic [MXLEN-1:0] pc;
    logic [1:0]       flt;
  } ent_t;

  state_t     state, state_nxt;
  ent_t       head, tail, push_ent;
  logic [1:0] count;
  logic       accept, misal, push, pop;

  assign pc_ready   = (state == IDLE) && (count != 2'd2) && !flush && RST_N;
  assign accept     = pc_valid && pc_ready;
  assign misal      = pc_val[1:0] != 2'b00;
  assign pop        = (count != 2'd0) && inst_ready && !flush;

  assign inst_valid = count != 2'd0;
  assign inst_data  = head.dat;
  assign inst_pc    = head.pc;
  assign inst_fault = head.flt;

  always_comb begin
    state_nxt    = state;
    push         = 1'b0;
    push_ent.dat = '0;
    push_ent.pc  = '0;
    push_ent.flt = 2'b00;
    case (state)
      IDLE: begin
        if (accept) begin
          if (misal) begin
            push         = 1'b1;
            push_ent.dat = NOP_INST;
            push_ent.pc  = pc_val;
            push_ent.flt = 2'b01;
          end else begin
            state_nxt = REQ;
          end
        end
      end
      REQ: begin
        // A grant coinciding with flush still leaves one response to discard.
        if (imem_gnt)   state_nxt = flush ? DRAIN : WAIT;
        else if (flush) state_nxt = DRAIN_REQ;
      end
      WAIT: begin
        if (imem_rvalid) begin
          state_nxt = IDLE;
          if (!flush) begin
            push         = 1'b1;
            push_ent.dat = imem_err ? NOP_INST : imem_rdata;
            push_ent.pc  = imem_addr;
            push_ent.flt = imem_err ? 2'b10 : 2'b00;
          end
        end else if (flush) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN_REQ: if (imem_gnt)    state_nxt = DRAIN;
      DRAIN:     if (imem_rvalid) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      imem_req  <= 1'b0;
      imem_addr <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= 2'd0;
    end else begin
      imem_req <= (state_nxt == REQ) || (state_nxt == DRAIN_REQ);
      if (state == IDLE && accept && !misal) imem_addr <= pc_val;

      if (flush) begin
        count <= 2'd0;
      end else begin
        case ({push, pop})
          2'b10: begin
            if (count == 2'd0) head <= push_ent;
            else               tail <= push_ent;
            count <= count + 2'd1;
          end
          2'b01: begin
            if (count == 2'd2) head <= tail;
            count <= count - 2'd1;
          end
          2'b11: begin
            if (count == 2'd1) begin
              head <= push_ent;
            end else begin
              head <= tail;
              tail <= push_ent;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
